onchip_memory_arbiter: RTL

ONCHIP_MEMORY_ARBITER -- requirements
Module: onchip_memory_arbiter

---
 rtl/onchip_memory_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/onchip_memory_arbiter.sv
// Two-master arbiter in front of a single-ported on-chip RAM.
// Ownership alternates under a bounded hold count when both masters
// compete. Read responses are tagged at accept time so that a grant switch
// cannot misroute data that is still in flight.
module onchip_memory_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DEPTH    = 30000,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    input  logic [31:0]       ram_readdata,
    output logic              oor_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [3:0]        holdCnt_q, holdCnt_d;
    logic              lastServed_q, lastServed_d;
    logic              rdValid_q, rdTarget_q, rdOor_q, oorError_q;

    logic              req0, req1, ownerIs1, ownReq, otherReq;
    logic              accepted, selWrite, inRange;
    logic [ADDR_W-1:0] selAddress;
    logic [31:0]       respData;

    // Decode requests and pick the owner's command for the RAM side
    always_comb begin
        req0       = m0_read | m0_write;
        req1       = m1_read | m1_write;
        ownerIs1   = (state_q == OWN1);
        ownReq     = ownerIs1 ? req1 : req0;
        otherReq   = ownerIs1 ? req0 : req1;
        accepted   = (state_q != IDLE) & ownReq;
        selAddress = ownerIs1 ? m1_address : m0_address;
        selWrite   = ownerIs1 ? m1_write : m0_write;
        inRange    = 32'(selAddress) < 32'(DEPTH);
    end

    assign m0_waitrequest = ~(accepted & ~ownerIs1);
    assign m1_waitrequest = ~(accepted & ownerIs1);

    assign ram_address    = selAddress;
    assign ram_byteenable = ownerIs1 ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = ownerIs1 ? m1_writedata : m0_writedata;
    assign ram_chipselect = accepted & inRange;
    assign ram_write      = ram_chipselect & selWrite;

    assign respData         = rdOor_q ? 32'h0 : ram_readdata;
    assign m0_readdatavalid = rdValid_q & ~rdTarget_q;
    assign m1_readdatavalid = rdValid_q & rdTarget_q;
    assign m0_readdata      = m0_readdatavalid ? respData : 32'h0;
    assign m1_readdata      = m1_readdatavalid ? respData : 32'h0;
    assign oor_error        = oorError_q;

    // Grant sequencing: tie-break on last served, bounded hold under contention
    always_comb begin
        state_d      = state_q;
        holdCnt_d    = holdCnt_q;
        lastServed_d = lastServed_q;
        case (state_q)
            IDLE: begin
                holdCnt_d = 4'd0;
                if (req0 && req1) begin
                    state_d = lastServed_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (ownReq) begin
                    lastServed_d = ownerIs1;
                    if (otherReq && (holdCnt_q == HOLD_LAST)) begin
                        state_d   = ownerIs1 ? OWN0 : OWN1;
                        holdCnt_d = 4'd0;
                    end else if (holdCnt_q != HOLD_LAST) begin
                        holdCnt_d = holdCnt_q + 4'd1;
                    end
                end else begin
                    holdCnt_d = 4'd0;
                    if (otherReq) begin
                        state_d = ownerIs1 ? OWN0 : OWN1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                holdCnt_d = 4'd0;
            end
        endcase
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            holdCnt_q    <= 4'd0;
            lastServed_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            holdCnt_q    <= holdCnt_d;
            lastServed_q <= lastServed_d;
        end
    end

    // Response tag captured at accept, plus the sticky out-of-range flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdValid_q  <= 1'b0;
            rdTarget_q <= 1'b0;
            rdOor_q    <= 1'b0;
            oorError_q <= 1'b0;
        end else begin
            rdValid_q  <= accepted & ~selWrite;
            rdTarget_q <= ownerIs1;
            rdOor_q    <= ~inRange;
            oorError_q <= oorError_q | (accepted & ~inRange);
        end
    end

endmodule
